data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of two, 4 to 65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states per access, 0 to 15.
REQ-003 SHALL have one clock and synchronous active-high reset: Clk  input  1  rising-edge clock.
REQ-004 SHALL have port Rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port Req  input  1  access request, sampled when Ready=1.
REQ-006 SHALL have port WriteEn  input  1  1=store, 0=load.
REQ-007 SHALL have port Size  input  2  00=byte, 01=half, 10=word, 11=reserved.
REQ-008 SHALL have port Unsigned  input  1  1=zero-extend loads, 0=sign-extend loads.
REQ-009 SHALL have port Address  input  32  byte address.
REQ-010 SHALL have port WriteData  input  32  store data, right-justified.
REQ-011 SHALL have port Ready  output  1  controller idle, request acceptable.
REQ-012 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port Error  output  1  valid with Done; access rejected.
REQ-014 SHALL have port ReadData  output  32  load result.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP; Ready=1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with Req=1 in IDLE, capture Address, Size, WriteEn, Unsigned and WriteData, then enter WAIT if WAIT_CYCLES>0, otherwise RESP.
REQ-017 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, then enter RESP.
REQ-018 SHALL assert Done for exactly the one RESP cycle, then return to IDLE; latency from acceptance edge to Done is WAIT_CYCLES+1 cycles.
REQ-019 SHALL ignore Req outside IDLE, with no queuing.
REQ-020 SHALL flag Error for: Size=11; half access with Address[0]=1; word access with Address[1:0]!=0; Address[31:2]>=DEPTH_WORDS.
REQ-021 SHALL commit a store to memory on the edge entering RESP, only when Error=0.
REQ-022 SHALL update a store by byte lane: byte writes lane Address[1:0] with WriteData[7:0]; half writes lanes {Address[1],0}+1:{Address[1],0} with WriteData[15:0]; word writes all 32 bits; untouched lanes are preserved.
REQ-023 SHALL produce load data from the addressed lane(s), right-justified and extended per Unsigned to 32 bits.
REQ-024 SHALL present load data on ReadData during RESP and hold it until the next successful load.
REQ-025 SHALL drive ReadData to 0 on an errored load.
REQ-026 SHALL leave ReadData unchanged on stores.
REQ-027 SHALL never modify memory on an errored access.
REQ-028 SHALL use word index Address[log2(DEPTH_WORDS)+1:2].
REQ-029 SHALL initialise memory at time zero to word[0]=20 and word[i]=i*3 for i>0; reset SHALL NOT alter memory contents.

Reset
REQ-030 SHALL, with Rst=1 on a rising edge, set state IDLE, Ready=1, Done=0, Error=0, ReadData=0 and clear the wait counter.
REQ-031 SHALL abort any access in progress when Rst is asserted mid-operation; an uncommitted store is discarded; Rst overrides a simultaneous Req.

Structure
REQ-032 SHALL place the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type in shared package data_mem_pkg.
REQ-033 SHALL implement lane selection, store merge and load extension in combinational sub-module mem_lane_align; the FSM, counter and memory array belong in data_mem_ctrl.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=2, load word at 0x0 -> Done 3 cycles after acceptance, ReadData=0x00000014, Error=0.
REQ-035 SHALL cover: store byte 0xAB at 0x9, then load word at 0x8 -> ReadData=0x0000AB06; load byte at 0x9 with Unsigned=0 -> 0xFFFFFFAB; with Unsigned=1 -> 0x000000AB.
REQ-036 SHALL cover: store half 0x8001 at 0xE, then load half at 0xE with Unsigned=0 -> 0xFFFF8001; load word at 0xC -> 0x80010009.
REQ-037 SHALL cover: store word at 0x6, Size=11, and address 0x1000 at DEPTH_WORDS=1024 -> each gives Done=1, Error=1, memory unchanged.
REQ-038 SHALL cover: Rst=1 during WAIT of a store to 0x4 -> Ready=1 next cycle, no Done, word[1] still 3.
REQ-039 SHALL cover: Req held high during WAIT -> ignored, exactly one Done; WAIT_CYCLES=0 -> Done on the cycle after acceptance.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory controller: access sizes and FSM state type.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane selection for a 32-bit word: merges store data into the addressed
// lane(s) and extracts/extends load data from them. Purely combinational.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    byte_sh     = {addr_lo, 3'b000};
    half_sh     = {addr_lo[1], 4'b0000};
    lane_b      = mem_word[byte_sh +: 8];
    lane_h      = mem_word[half_sh +: 16];
    merged_word = mem_word;
    load_data   = '0;
    case (size)
      SZ_BYTE: begin
        merged_word[byte_sh +: 8] = wdata[7:0];
        load_data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      end
      SZ_HALF: begin
        merged_word[half_sh +: 16] = wdata[15:0];
        load_data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      end
      SZ_WORD: begin
        merged_word = wdata;
        load_data   = mem_word;
      end
      default: begin
        merged_word = mem_word;
        load_data   = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with a fixed number of wait states per access,
// byte/half/word accesses, alignment and range checking.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        WriteEn,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic        Ready,
  output logic        Done,
  output logic        Error,
  output logic [31:0] ReadData,
  output state_t      dbg_state
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef logic [31:0] mem_t [DEPTH_WORDS];

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
      m[i] = (i == 0) ? 32'd20 : 32'(i * 3);
    end
    return m;
  endfunction

  // Power-up contents; reset deliberately leaves the array alone.
  mem_t mem_q = mem_init();

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic          in_idle;
  logic [31:0]   cur_addr;
  logic [1:0]    cur_size;
  logic          cur_we;
  logic          cur_uns;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] cur_idx;
  logic          cur_err;
  logic          enter_resp;
  logic          mem_we;
  logic [31:0]   mem_word;
  logic [31:0]   merged_word;
  logic [31:0]   load_data;

  // In IDLE the access may go straight to RESP, so use live inputs there.
  always_comb begin
    in_idle   = (state_q == IDLE);
    cur_addr  = in_idle ? Address   : addr_q;
    cur_size  = in_idle ? Size      : size_q;
    cur_we    = in_idle ? WriteEn   : we_q;
    cur_uns   = in_idle ? Unsigned  : uns_q;
    cur_wdata = in_idle ? WriteData : wdata_q;
    cur_idx   = cur_addr[AW+1:2];
    mem_word  = mem_q[cur_idx];
    cur_err   = (cur_size == SZ_RSVD)
              | ((cur_size == SZ_HALF) & cur_addr[0])
              | ((cur_size == SZ_WORD) & (cur_addr[1:0] != 2'b00))
              | ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);
  end

  mem_lane_align u_align (
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .addr_lo     (cur_addr[1:0]),
    .wdata       (cur_wdata),
    .mem_word    (mem_word),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    we_d       = we_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req) begin
          addr_d  = Address;
          size_d  = Size;
          we_d    = WriteEn;
          uns_d   = Unsigned;
          wdata_d = WriteData;
          if (WAIT_CYCLES > 0) begin
            state_d    = WAIT;
            wait_cnt_d = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp && !cur_we) begin
      rdata_d = cur_err ? 32'd0 : load_data;
    end
    mem_we = enter_resp & cur_we & ~cur_err & ~Rst;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[cur_idx] <= merged_word;
    end
  end

  assign Ready     = (state_q == IDLE);
  assign Done      = (state_q == RESP);
  assign Error     = (state_q == RESP) & cur_err;
  assign ReadData  = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed and random accesses checked by a scoreboard
// against a byte-addressed memory model; a second instance covers zero wait states.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
  import data_mem_pkg::*;

  localparam int WAITS = 2;
  localparam int DEPTH = 1024;
  localparam int EXP_W = 65;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Rst, Req, WriteEn, Unsigned;
  logic [1:0]  Size;
  logic [31:0] Address, WriteData;
  logic        Ready, Done, Error;
  logic [31:0] ReadData;
  state_t      dbg_state;

  logic        z_rst, z_req, z_we, z_uns;
  logic [1:0]  z_size;
  logic [31:0] z_addr, z_wdata;
  logic        z_ready, z_done, z_error;
  logic [31:0] z_rdata;
  state_t      z_dbg;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .Clk(clk), .Rst(Rst), .Req(Req), .WriteEn(WriteEn), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
    .Ready(Ready), .Done(Done), .Error(Error), .ReadData(ReadData),
    .dbg_state(dbg_state)
  );

  data_mem_ctrl #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
    .Clk(clk), .Rst(z_rst), .Req(z_req), .WriteEn(z_we), .Size(z_size),
    .Unsigned(z_uns), .Address(z_addr), .WriteData(z_wdata),
    .Ready(z_ready), .Done(z_done), .Error(z_error), .ReadData(z_rdata),
    .dbg_state(z_dbg)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] ref_rdata;

  function automatic void model_init();
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = (i == 0) ? 32'd20 : 32'(i * 3);
      for (int k = 0; k < 4; k++) ref_mem[i*4+k] = w[8*k +: 8];
    end
    ref_rdata = 32'd0;
  endfunction

  // Returns {error, ReadData after the access}.
  function automatic logic [32:0] model_access(input logic we, input logic [1:0] sz,
                                               input logic uns, input logic [31:0] a,
                                               input logic [31:0] wd);
    int nbytes;
    logic err;
    logic [31:0] v;
    err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
          || (a / 4 >= DEPTH);
    if (err) begin
      if (!we) ref_rdata = 32'd0;
      return {1'b1, ref_rdata};
    end
    nbytes = 1 << sz;
    if (we) begin
      for (int k = 0; k < nbytes; k++) ref_mem[a + k] = wd[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < nbytes; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
      ref_rdata = v;
    end
    return {1'b0, ref_rdata};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0] last_rd;
  logic        last_err;
  int          done_cnt = 0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (Done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=Done exp=no_done t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("done_error", {31'd0, Error}, {31'd0, e[64]});
        check("read_data", ReadData, e[63:32]);
        check("latency", 32'(cyc) - e[31:0], 32'(WAITS + 1));
        check("ready_low_in_resp", {31'd0, Ready}, 32'd0);
        last_rd  = ReadData;
        last_err = Error;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = Ready;
    if (!ok) timeout_fail("ready_wait");
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold);
    bit ok;
    int n;
    logic [32:0] r;
    wait_ready(ok);
    if (!ok) return;
    Req = 1'b1; WriteEn = we; Size = sz; Unsigned = uns; Address = a; WriteData = wd;
    r = model_access(we, sz, uns, a, wd);
    exp_q.push_back({r, 32'(cyc)});
    @(posedge clk);
    #1;
    if (hold) begin
      n = 0;
      while (!Done && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!Done) timeout_fail("held_done_wait");
    end
    Req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout_fail("drain");
    @(negedge clk);
    #1;
  endtask

  task automatic abort_store();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    Req = 1'b1; WriteEn = 1'b1; Size = SZ_WORD; Unsigned = 1'b0;
    Address = 32'h4; WriteData = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    Req = 1'b0;
    @(negedge clk);
    check("abort_in_wait", 32'(dbg_state), 32'(WAIT));
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    ref_rdata = 32'd0;
    check("abort_ready", {31'd0, Ready}, 32'd1);
    check("abort_no_done", {31'd0, Done}, 32'd0);
    check("abort_rdata_cleared", ReadData, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    logic [1:0]  rs;
    logic [31:0] ra;
    Rst = 1'b1; Req = 1'b0; WriteEn = 1'b0; Size = SZ_WORD; Unsigned = 1'b0;
    Address = '0; WriteData = '0;
    z_rst = 1'b1; z_req = 1'b0; z_we = 1'b0; z_size = SZ_WORD; z_uns = 1'b0;
    z_addr = '0; z_wdata = '0;
    last_rd = '0; last_err = 1'b0;
    model_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, Ready}, 32'd1);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_error", {31'd0, Error}, 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    Rst = 1'b0;
    z_rst = 1'b0;

    issue(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0); drain();
    check("load_w0", last_rd, 32'h0000_0014);
    check("load_w0_err", {31'd0, last_err}, 32'd0);

    issue(1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h0000_00AB, 1'b0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b0); drain();
    check("byte_merge_word", last_rd, 32'h0000_AB06);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0, 1'b0); drain();
    check("load_byte_signed", last_rd, 32'hFFFF_FFAB);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0, 1'b0); drain();
    check("load_byte_unsigned", last_rd, 32'h0000_00AB);

    issue(1'b1, SZ_HALF, 1'b0, 32'hE, 32'h0000_8001, 1'b0);
    issue(1'b0, SZ_HALF, 1'b0, 32'hE, 32'h0, 1'b0); drain();
    check("load_half_signed", last_rd, 32'hFFFF_8001);
    issue(1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0, 1'b0); drain();
    check("half_merge_word", last_rd, 32'h8001_0009);

    issue(1'b1, SZ_WORD, 1'b0, 32'h6, 32'h1111_1111, 1'b0); drain();
    check("err_misaligned_word", {31'd0, last_err}, 32'd1);
    issue(1'b1, SZ_RSVD, 1'b0, 32'h10, 32'h2222_2222, 1'b0); drain();
    check("err_reserved_size", {31'd0, last_err}, 32'd1);
    issue(1'b1, SZ_WORD, 1'b0, 32'h1000, 32'h3333_3333, 1'b0); drain();
    check("err_out_of_range", {31'd0, last_err}, 32'd1);
    check("err_store_keeps_rdata", last_rd, 32'h8001_0009);
    issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0); drain();
    check("w1_unchanged", last_rd, 32'h0000_0003);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0); drain();
    check("w4_unchanged", last_rd, 32'h0000_000C);
    issue(1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0, 1'b0); drain();
    check("err_load_zero", last_rd, 32'h0);

    abort_store();
    repeat (5) @(negedge clk);
    issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0); drain();
    check("abort_w1_still_3", last_rd, 32'h0000_0003);

    d0 = done_cnt;
    issue(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b1); drain();
    repeat (6) @(negedge clk);
    check("held_req_one_done", 32'(done_cnt - d0), 32'd1);

    for (int i = 0; i < 150; i++) begin
      rs = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       ra = 32'h1000 + 32'($urandom_range(0, 63));
        1:       ra = $urandom;
        default: ra = 32'($urandom_range(0, 255));
      endcase
      issue(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom, 1'b0);
    end
    drain();

    @(negedge clk);
    z_req = 1'b1; z_we = 1'b0; z_size = SZ_WORD; z_addr = 32'h8;
    @(posedge clk);
    #1;
    z_req = 1'b0;
    @(negedge clk);
    check("w0_done_next_cycle", {31'd0, z_done}, 32'd1);
    check("w0_rdata", z_rdata, 32'd6);
    check("w0_error", {31'd0, z_error}, 32'd0);
    @(negedge clk);
    check("w0_done_one_cycle", {31'd0, z_done}, 32'd0);
    check("w0_ready_back", {31'd0, z_ready}, 32'd1);
    z_req = 1'b1; z_we = 1'b0; z_size = SZ_WORD; z_addr = 32'h40;
    @(posedge clk);
    #1;
    z_req = 1'b0;
    @(negedge clk);
    check("w0_range_done", {31'd0, z_done}, 32'd1);
    check("w0_range_error", {31'd0, z_error}, 32'd1);
    check("w0_range_rdata", z_rdata, 32'd0);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
